// File: rtl/lcd_escritor_if.sv
// Signal bundle between the driver-selection logic, lcd_escritor and the LCD pins.
interface lcd_escritor_if;
  logic [127:0] linha1;
  logic [127:0] linha2;
  logic         atualiza;
  logic [7:0]   LCD_DATA;
  logic         LCD_RS;
  logic         LCD_RW;
  logic         LCD_EN;
  logic         LCD_ON;
  logic         pronto;

  modport master (
    output linha1, linha2, atualiza,
    input  LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON, pronto
  );

  modport slave (
    input  linha1, linha2, atualiza,
    output LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON, pronto
  );
endinterface

// File: rtl/lcd_escritor.sv
// HD44780 16x2 writer: power-on init, then snapshots and writes both text lines on request.
// Build option AUTO_REFRESH_EN adds a periodic internal refresh request every REFRESH_CYC cycles.
//   state    | meaning
//   PWR_WAIT | power-on delay        INIT  | 0x38,0x0C,0x01,0x06
//   IDLE     | ready for a request   SNAP  | latch both lines
//   ADDR1/2  | DDRAM address cmd     CHR1/2| 16 characters, RS=1
module lcd_escritor #(
  parameter int unsigned EN_PULSE_CYC     = 20,
  parameter int unsigned CMD_WAIT_CYC     = 2000,
  parameter int unsigned CLEAR_WAIT_CYC   = 82000,
  parameter int unsigned POWERON_WAIT_CYC = 750000
`ifdef AUTO_REFRESH_EN
  , parameter int unsigned REFRESH_CYC    = 5000000
`endif
) (
  input logic           clk,
  input logic           rst_n,
  lcd_escritor_if.slave bus
);

  typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, SNAP, ADDR1, CHR1, ADDR2, CHR2} state_e;
  typedef enum logic [1:0] {PH_SETUP, PH_EN, PH_WAIT} phase_e;

  localparam logic [31:0] PWR_LAST = 32'(POWERON_WAIT_CYC - 1);
  localparam logic [31:0] EN_LAST  = 32'(EN_PULSE_CYC - 1);
  localparam logic [31:0] CMD_LAST = 32'(CMD_WAIT_CYC - 1);
  localparam logic [31:0] CLR_LAST = 32'(CLEAR_WAIT_CYC - 1);

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic             pend_q, pend_d;
  logic [31:0][7:0] snap_q, snap_d;
  logic             req;
  logic             xfer;
  logic             byte_done;
  logic [7:0]       cur_byte;
  logic             cur_rs;
  logic [31:0]      wait_last;

`ifdef AUTO_REFRESH_EN
  localparam logic [31:0] REF_LAST = 32'(REFRESH_CYC - 1);
  logic [31:0] ref_q, ref_d;
  logic        auto_req;

  always_comb begin
    ref_d    = ref_q;
    auto_req = 1'b0;
    if (state_q != PWR_WAIT && state_q != INIT) begin
      if (ref_q == REF_LAST) begin
        auto_req = 1'b1;
        ref_d    = '0;
      end else begin
        ref_d = ref_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ref_q <= '0;
    else        ref_q <= ref_d;
  end

  assign req = bus.atualiza | auto_req;
`else
  assign req = bus.atualiza;
`endif

  // Snapshot packing: line-1 char i is byte 31-i, line-2 char i is byte 15-i.
  always_comb begin
    cur_byte = 8'h00;
    cur_rs   = 1'b0;
    case (state_q)
      INIT: begin
        case (idx_q[1:0])
          2'd0:    cur_byte = 8'h38;
          2'd1:    cur_byte = 8'h0C;
          2'd2:    cur_byte = 8'h01;
          default: cur_byte = 8'h06;
        endcase
      end
      ADDR1: cur_byte = 8'h80;
      CHR1: begin
        cur_byte = snap_q[5'd31 - {1'b0, idx_q}];
        cur_rs   = 1'b1;
      end
      ADDR2: cur_byte = 8'hC0;
      CHR2: begin
        cur_byte = snap_q[5'd15 - {1'b0, idx_q}];
        cur_rs   = 1'b1;
      end
      default: cur_byte = 8'h00;
    endcase
  end

  assign xfer      = (state_q == INIT) || (state_q == ADDR1) || (state_q == CHR1) ||
                     (state_q == ADDR2) || (state_q == CHR2);
  assign wait_last = (!cur_rs && cur_byte == 8'h01) ? CLR_LAST : CMD_LAST;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q + 32'd1;
    idx_d     = idx_q;
    snap_d    = snap_q;
    byte_done = 1'b0;
    pend_d    = pend_q;

    // A request arriving while SNAP latches is kept for the next refresh.
    if (state_q == SNAP)                 pend_d = req;
    else if (state_q != IDLE && req)     pend_d = 1'b1;

    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          state_d = INIT;
          phase_d = PH_SETUP;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      IDLE: begin
        cnt_d = '0;
        if (req || pend_q) state_d = SNAP;
      end
      SNAP: begin
        snap_d  = {bus.linha1, bus.linha2};
        state_d = ADDR1;
        phase_d = PH_SETUP;
        cnt_d   = '0;
        idx_d   = '0;
      end
      default: begin
        case (phase_q)
          PH_SETUP: begin
            phase_d = PH_EN;
            cnt_d   = '0;
          end
          PH_EN: begin
            if (cnt_q == EN_LAST) begin
              phase_d = PH_WAIT;
              cnt_d   = '0;
            end
          end
          default: begin
            if (cnt_q == wait_last) byte_done = 1'b1;
          end
        endcase
      end
    endcase

    if (byte_done) begin
      phase_d = PH_SETUP;
      cnt_d   = '0;
      idx_d   = idx_q + 4'd1;
      case (state_q)
        INIT:  if (idx_q == 4'd3) state_d = IDLE;
        ADDR1: begin state_d = CHR1; idx_d = '0; end
        CHR1:  if (idx_q == 4'd15) state_d = ADDR2;
        ADDR2: begin state_d = CHR2; idx_d = '0; end
        CHR2:  if (idx_q == 4'd15) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PWR_WAIT;
      phase_q <= PH_SETUP;
      cnt_q   <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      snap_q  <= snap_d;
    end
  end

  assign bus.LCD_DATA = cur_byte;
  assign bus.LCD_RS   = cur_rs;
  assign bus.LCD_EN   = xfer && (phase_q == PH_EN);
  assign bus.LCD_RW   = 1'b0;
  assign bus.LCD_ON   = 1'b1;
  assign bus.pronto   = (state_q == IDLE) && !pend_q;

endmodule

// File: tb/tb_lcd_escritor.sv
// Bench for lcd_escritor: per-cycle schedule model of expected LCD bus activity,
// directed scenarios with literal expectations, then randomized requests/resets.
module tb_lcd_escritor;
  localparam int EN_P  = 2;
  localparam int CMD_W = 4;
  localparam int CLR_W = 8;
  localparam int PWR_W = 10;
`ifdef AUTO_REFRESH_EN
  localparam int REF_P = 400;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lcd_escritor_if ifc ();

  lcd_escritor #(
    .EN_PULSE_CYC(EN_P),
    .CMD_WAIT_CYC(CMD_W),
    .CLEAR_WAIT_CYC(CLR_W),
    .POWERON_WAIT_CYC(PWR_W)
`ifdef AUTO_REFRESH_EN
    , .REFRESH_CYC(REF_P)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(ifc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: queue of expected cycles ----------------
  localparam logic [1:0] K_PWR = 2'd0, K_INIT = 2'd1, K_SNAP = 2'd2, K_REF = 2'd3;
  typedef struct packed {
    logic [1:0] kind;
    logic       en;
    logic [7:0] data;
    logic       rs;
  } ent_t;

  ent_t sched[$];
  bit   m_pend = 1'b0;
  bit   m_on   = 1'b0;
  int   m_ref  = 0;
  int   cyc    = 0;
  int   rst_cyc = 0;
  ent_t m_e;
  bit   m_req, m_auto;

  task automatic push_byte(input logic [7:0] d, input logic rs, input logic [1:0] k);
    int w;
    w = (!rs && d == 8'h01) ? CLR_W : CMD_W;
    sched.push_back('{k, 1'b0, d, rs});
    repeat (EN_P) sched.push_back('{k, 1'b1, d, rs});
    repeat (w) sched.push_back('{k, 1'b0, d, rs});
  endtask

  task automatic push_line(input logic [127:0] l, input logic [7:0] addr);
    logic [127:0] t;
    push_byte(addr, 1'b0, K_REF);
    for (int i = 0; i < 16; i++) begin
      t = l >> (8 * (15 - i));
      push_byte(t[7:0], 1'b1, K_REF);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      sched.delete();
      repeat (PWR_W) sched.push_back('{K_PWR, 1'b0, 8'h00, 1'b0});
      push_byte(8'h38, 1'b0, K_INIT);
      push_byte(8'h0C, 1'b0, K_INIT);
      push_byte(8'h01, 1'b0, K_INIT);
      push_byte(8'h06, 1'b0, K_INIT);
      m_pend  = 1'b0;
      m_ref   = 0;
      m_on    = 1'b1;
      rst_cyc = cyc;
    end else if (m_on) begin
      m_auto = 1'b0;
`ifdef AUTO_REFRESH_EN
      if (sched.size() == 0 || sched[0].kind inside {K_SNAP, K_REF}) begin
        if (m_ref == REF_P - 1) begin
          m_auto = 1'b1;
          m_ref  = 0;
        end else begin
          m_ref++;
        end
      end
`endif
      m_req = ifc.atualiza | m_auto;
      if (sched.size() == 0) begin
        if (m_req || m_pend) sched.push_back('{K_SNAP, 1'b0, 8'h00, 1'b0});
      end else begin
        m_e = sched.pop_front();
        if (m_e.kind == K_SNAP) begin
          m_pend = m_req;
          push_line(ifc.linha1, 8'h80);
          push_line(ifc.linha2, 8'hC0);
        end else if (m_req) begin
          m_pend = 1'b1;
        end
      end
    end
  end

  ent_t c_e;
  bit   c_pr;
  always @(negedge clk) begin
    if (m_on) begin
      c_e  = (sched.size() > 0) ? sched[0] : '0;
      c_pr = (sched.size() == 0) && !m_pend;
      chk($sformatf("bus@%0d", cyc - rst_cyc),
          {18'd0, ifc.LCD_EN, ifc.LCD_DATA, ifc.LCD_RS, ifc.pronto, ifc.LCD_RW, ifc.LCD_ON},
          {18'd0, c_e.en, c_e.data, c_e.rs, c_pr, 1'b0, 1'b1});
    end
  end

  // ---------------- bus monitor: one record per EN pulse ----------------
  logic [7:0] cap_d[$];
  logic       cap_r[$];
  int         cap_t[$];
  int         cap_w[$];
  bit         prev_en = 1'b0;
  int         run = 0;

  always @(negedge clk) begin
    if (ifc.LCD_EN === 1'b1) begin
      if (!prev_en) begin
        cap_d.push_back(ifc.LCD_DATA);
        cap_r.push_back(ifc.LCD_RS);
        cap_t.push_back(cyc - rst_cyc);
      end
      run++;
    end else if (prev_en) begin
      cap_w.push_back(run);
      run = 0;
    end
    prev_en = (ifc.LCD_EN === 1'b1);
  end

  function automatic logic [8:0] cap(input int i);
    return (i < cap_d.size()) ? {cap_r[i], cap_d[i]} : 9'h1FF;
  endfunction

  function automatic int capt(input int i);
    return (i < cap_t.size()) ? cap_t[i] : -1;
  endfunction

  task automatic clear_cap();
    cap_d.delete();
    cap_r.delete();
    cap_t.delete();
    cap_w.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    tick(1);
    ifc.atualiza = 1'b1;
    tick(1);
    ifc.atualiza = 1'b0;
  endtask

  task automatic wait_pronto(input int budget, output int low);
    low = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ifc.pronto === 1'b1) return;
      low++;
    end
    chk("pronto_timeout", {31'd0, ifc.pronto}, 32'd1);
  endtask

  task automatic wait_caps(input int k, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cap_d.size() >= k) return;
    end
    chk("cap_timeout", cap_d.size(), k);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int           low;
    logic [127:0] orig, t;
    logic [7:0]   b;

    rst_n        = 1'b0;
    ifc.atualiza = 1'b0;
    ifc.linha1   = '0;
    ifc.linha2   = '0;
    tick(3);
    rst_n = 1'b1;

    // power-on wait and init sequence
    wait_pronto(200, low);
    chk("pronto_rise_cycle", cyc - rst_cyc, 42);
    chk("init_count", cap_d.size(), 4);
    chk("init0", cap(0), {1'b0, 8'h38});
    chk("init1", cap(1), {1'b0, 8'h0C});
    chk("init2", cap(2), {1'b0, 8'h01});
    chk("init3", cap(3), {1'b0, 8'h06});
    chk("init_first_en", capt(0), 11);
    chk("gap_38_0c", capt(1) - capt(0), 7);
    chk("gap_0c_01", capt(2) - capt(1), 7);
    chk("gap_01_06", capt(3) - capt(2), 11);
    chk("en_pulses", cap_w.size(), 4);
    for (int i = 0; i < cap_w.size(); i++) chk("en_width", cap_w[i], EN_P);

    // single refresh with the reference strings
    tick(3);
    ifc.linha1 = "Joao Rodrigues  ";
    ifc.linha2 = "Fiat-Uno        ";
    clear_cap();
    pulse();
    wait_pronto(400, low);
    chk("refresh_low_cycles", low, 239);  // SNAP plus 34 bytes of 7 cycles
    chk("refresh_count", cap_d.size(), 34);
    chk("ref0", cap(0), {1'b0, 8'h80});
    chk("ref1", cap(1), {1'b1, 8'h4A});
    chk("ref2", cap(2), {1'b1, 8'h6F});
    chk("ref3", cap(3), {1'b1, 8'h61});
    chk("ref4", cap(4), {1'b1, 8'h6F});
    chk("ref5", cap(5), {1'b1, 8'h20});
    chk("ref17", cap(17), {1'b0, 8'hC0});
    chk("ref18", cap(18), {1'b1, 8'h46});
    chk("ref19", cap(19), {1'b1, 8'h69});
    chk("ref33", cap(33), {1'b1, 8'h20});

    // input change mid-line must not tear the snapshot
    tick(2);
    orig = "abcdefghijklmnop";
    ifc.linha1 = orig;
    clear_cap();
    pulse();
    wait_caps(7, 200);
    tick(1);
    ifc.linha1 = {16{8'h41}};
    wait_pronto(400, low);
    for (int i = 6; i < 16; i++) begin
      t = orig >> (8 * (15 - i));
      chk($sformatf("no_tear_char%0d", i), cap(i + 1), {1'b1, t[7:0]});
    end

    // several requests during one refresh collapse into one more refresh
    tick(2);
    clear_cap();
    pulse();
    wait_caps(3, 100);
    pulse();
    tick(5);
    pulse();
    tick(30);
    pulse();
    wait_pronto(800, low);
    tick(50);
`ifndef AUTO_REFRESH_EN
    chk("collapse_bytes", cap_d.size(), 68);
`endif

    // reset in the middle of line 2
    clear_cap();
    pulse();
    wait_caps(25, 400);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_en", {31'd0, ifc.LCD_EN}, 32'd0);
    chk("rst_data", {24'd0, ifc.LCD_DATA}, 32'd0);
    chk("rst_pronto", {31'd0, ifc.pronto}, 32'd0);
    tick(1);
    clear_cap();
    wait_pronto(200, low);
    chk("reinit_pronto_cycle", cyc - rst_cyc, 42);
    tick(300);
    chk("reinit_bytes", cap_d.size(), 4);
    for (int i = 0; i < cap_r.size(); i++) chk("reinit_rs", {31'd0, cap_r[i]}, 32'd0);

    // idle bus activity
    clear_cap();
    tick(1000);
`ifndef AUTO_REFRESH_EN
    chk("idle_quiet", cap_d.size(), 0);
`else
    chk("auto_refresh_seen", {31'd0, cap_d.size() > 0}, 32'd1);
`endif

    // randomized requests, levels, data and resets
    for (int it = 0; it < 60; it++) begin
      ifc.linha1 = {$urandom, $urandom, $urandom, $urandom};
      ifc.linha2 = {$urandom, $urandom, $urandom, $urandom};
      if (it == 0) begin
        ifc.linha2 = {16{8'h01}};
      end else if ($urandom_range(0, 3) == 0) begin
        b = 8'($urandom_range(0, 7));
        ifc.linha1 = {16{b}};
      end
      case ($urandom_range(0, 9))
        0: begin
          rst_n = 1'b0;
          tick($urandom_range(1, 3));
          rst_n = 1'b1;
        end
        1, 2: begin
          ifc.atualiza = 1'b1;
          tick($urandom_range(1, 8));
          ifc.atualiza = 1'b0;
        end
        default: pulse();
      endcase
      tick($urandom_range(0, 500));
    end

    ifc.atualiza = 1'b0;
    wait_pronto(2000, low);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lcd_escritor.md
Name: lcd_escritor

Overview:
- Display-side consumer of the driver-info text bytes (16-char driver name line, 16-char car model line) produced by the driver-selection logic.
- Runs the HD44780-compatible 16x2 character LCD power-on init sequence, then on request writes both lines.
- Generates all LCD bus timing (RS/RW/EN/DATA) from the system clock.
- Sits between the selection logic and the board LCD pins.

Parameters:
- EN_PULSE_CYC, 20: cycles LCD_EN is held high per transfer.
- CMD_WAIT_CYC, 2000: cycles of EN-low wait after a normal command or character (40 us at 50 MHz).
- CLEAR_WAIT_CYC, 82000: wait after the clear-display command 0x01 (1.64 ms).
- POWERON_WAIT_CYC, 750000: wait after reset before the first command (15 ms).
- REFRESH_CYC, 5000000: auto-refresh period; used only with AUTO_REFRESH_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- linha1  in  128  line-1 characters; char 0 (leftmost) in [127:120], char 15 in [7:0]
- linha2  in  128  line-2 characters, same packing
- atualiza  in  1  refresh request, sampled every cycle; level or pulse accepted
- LCD_DATA  out  8  LCD data bus
- LCD_RS  out  1  0 = command, 1 = character data
- LCD_RW  out  1  write only, constant 0
- LCD_EN  out  1  LCD enable strobe
- LCD_ON  out  1  LCD power, constant 1
- pronto  out  1  1 only in IDLE with no pending request

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - LCD_DATA = 0x00, LCD_RS = 0, LCD_RW = 0, LCD_EN = 0, LCD_ON = 1, pronto = 0.
  - Pending flag cleared, all counters cleared, state = PWR_WAIT.
  - Asserting reset mid-transfer aborts immediately; init restarts from PWR_WAIT.
- Byte transfer (identical for commands and characters):
  - Setup: 1 cycle with DATA/RS driven and EN = 0.
  - Enable: EN = 1 for EN_PULSE_CYC cycles, DATA/RS unchanged.
  - Wait: EN = 0 for the wait count, DATA/RS held. Wait is CLEAR_WAIT_CYC for command 0x01, otherwise CMD_WAIT_CYC.
  - Total per byte = 1 + EN_PULSE_CYC + wait.
- States:
  - PWR_WAIT: count POWERON_WAIT_CYC cycles, then go to INIT.
  - INIT: commands 0x38, 0x0C, 0x01, 0x06 in that order, then go to IDLE.
  - IDLE: pronto = 1 unless a request is pending. Leave IDLE on atualiza = 1 or pending = 1.
  - SNAP (1 cycle): latch linha1/linha2 into internal 256-bit registers; clear pending; pronto = 0.
  - ADDR1: command 0x80.
  - CHR1: 16 characters from the snapshot, char 0 first, RS = 1.
  - ADDR2: command 0xC0.
  - CHR2: 16 characters from the snapshot, char 0 first, RS = 1.
  - After CHR2, return to IDLE.
- Per-character index: 4-bit counter; wraps from 15 to 0 on the state change.
- Requests outside IDLE:
  - atualiza = 1 in any state other than IDLE (including PWR_WAIT/INIT) sets the single-depth pending flag.
  - Multiple requests collapse into one.
  - A pending request is serviced on the first IDLE cycle.
- Input changes after SNAP do not affect the refresh in progress (no tearing).
- Character codes are sent verbatim, with no translation. 0x00–0x07 are allowed.

Optional Feature:
- Macro: AUTO_REFRESH_EN.
- Defined:
  - A free-running counter, cleared by reset, asserts an internal request every REFRESH_CYC cycles.
  - It ORs with atualiza and uses the same pending/collapse rules.
  - The counter runs in all states except PWR_WAIT and INIT.
- Undefined: no counter is instantiated; refresh happens only on atualiza.

Test Plan (EN_PULSE_CYC=2, CMD_WAIT_CYC=4, CLEAR_WAIT_CYC=8, POWERON_WAIT_CYC=10; normal byte = 7 cycles, clear = 11 cycles):
- Reset then release -> EN stays 0 for 10 cycles. Then commands 0x38, 0x0C, 0x01, 0x06, each with EN high for exactly 2 cycles and RS = 0. Gap after 0x01 is 8 cycles. pronto rises 1 cycle after the 0x06 wait ends.
- In IDLE, linha1 = "Joao Rodrigues  ", linha2 = "Fiat-Uno       ", 1-cycle atualiza pulse -> 34 EN pulses in order: 0x80, 0x4A 0x6F 0x61 0x6F 0x20 ..., 0xC0, 0x46 0x69 ... 0x20. RS = 1 only on characters. Total 238 cycles; pronto = 0 throughout, 1 afterwards.
- Change linha1 to all 0x41 during CHR1 char 5 -> remaining line-1 characters still match the original snapshot.
- Three atualiza pulses during one refresh -> exactly one additional 238-cycle refresh follows, then pronto = 1.
- rst_n low for 1 cycle during CHR2 -> next cycle EN = 0, DATA = 0x00, pronto = 0. Full init sequence repeats with no character writes until a new request arrives.
- With AUTO_REFRESH_EN and REFRESH_CYC = 400, no atualiza -> a refresh starts every 400 cycles after init. Without the macro -> no EN activity after init.
